obi_wb_bridge: RTL and testbench

OBI_WB_BRIDGE -- requirements
Module: obi_wb_bridge

---
 rtl/obi_wb_pkg.sv | 13 +
 rtl/obi_wb_bridge_if.sv | 39 +++
 rtl/obi_wb_bridge.sv | 94 +++++++++
 tb/tb_obi_wb_bridge.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/obi_wb_pkg.sv
// Shared definitions for the OBI-to-Wishbone bridge: state encoding,
// wait-counter width and the default Wishbone timeout.
package obi_wb_pkg;

  localparam int unsigned CNT_W                  = 16;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_e;

endpackage

// File: rtl/obi_wb_bridge_if.sv
// Bundle of the OBI request/response and Wishbone master signals around
// one bridge; the slave modport is the bridge's view of the bundle.
interface obi_wb_bridge_if;

  logic        req;
  logic        gnt;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack;
  logic        wb_err;

  // Bridge side: takes OBI requests and Wishbone responses.
  modport slave (
    input  req, we, be, addr, wdata, wb_dat_i, wb_ack, wb_err,
    output gnt, rvalid, rdata, err,
    output wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_o
  );

  // Environment side: the core issuing requests and the Wishbone target.
  modport master (
    output req, we, be, addr, wdata, wb_dat_i, wb_ack, wb_err,
    input  gnt, rvalid, rdata, err,
    input  wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_o
  );

endinterface

// File: rtl/obi_wb_bridge.sv
// Single-outstanding OBI slave to Wishbone classic master bridge with a
// bounded wait for ack/err; a timeout is answered as an error response.
module obi_wb_bridge
  import obi_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES   = DEFAULT_TIMEOUT_CYCLES,
  parameter bit          ZERO_WRITE_RDATA = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,

  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  state_e           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_inc;

  // Grant is combinational so a new request can be taken in the rvalid cycle.
  assign gnt_o        = (state == IDLE) && req_i;
  assign wb_cyc_o     = (state == BUS);
  assign wb_stb_o     = (state == BUS);
  assign wait_cnt_inc = wait_cnt + 1'b1;

  // NOTE: every register here updates with <= so all of them sample the
  // pre-edge values of each other; a blocking = would create ordering races.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      wb_we_o  <= 1'b0;
      wb_sel_o <= '0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      rvalid_o <= 1'b0;
      err_o    <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i) begin
            wb_we_o  <= we_i;
            wb_sel_o <= be_i;
            wb_adr_o <= addr_i;
            wb_dat_o <= wdata_i;
            wait_cnt <= '0;
            state    <= BUS;
          end
        end
        BUS: begin
          if (wb_ack_i || wb_err_i) begin
            // Error takes precedence over a simultaneous ack and hides the data.
            state    <= IDLE;
            rvalid_o <= 1'b1;
            err_o    <= wb_err_i;
            rdata_o  <= (wb_err_i || (wb_we_o && ZERO_WRITE_RDATA)) ? '0 : wb_dat_i;
          end else if (wait_cnt_inc == TIMEOUT_VAL) begin
            state    <= IDLE;
            rvalid_o <= 1'b1;
            err_o    <= 1'b1;
            rdata_o  <= '0;
            wait_cnt <= wait_cnt_inc;
          end else begin
            wait_cnt <= wait_cnt_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obi_wb_bridge.sv
// Randomised bench for obi_wb_bridge: a bench-side Wishbone target with
// chosen wait states/response kinds, checked against a transaction-level model.
module tb_obi_wb_bridge;

  localparam int T = 4;

  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_BOTH = 2;
  localparam int K_NONE = 3;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  obi_wb_bridge_if bus ();

  obi_wb_bridge #(
    .TIMEOUT_CYCLES  (T),
    .ZERO_WRITE_RDATA(1'b1)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .req_i   (bus.req),
    .gnt_o   (bus.gnt),
    .we_i    (bus.we),
    .be_i    (bus.be),
    .addr_i  (bus.addr),
    .wdata_i (bus.wdata),
    .rvalid_o(bus.rvalid),
    .rdata_o (bus.rdata),
    .err_o   (bus.err),
    .wb_cyc_o(bus.wb_cyc),
    .wb_stb_o(bus.wb_stb),
    .wb_we_o (bus.wb_we),
    .wb_sel_o(bus.wb_sel),
    .wb_adr_o(bus.wb_adr),
    .wb_dat_o(bus.wb_dat_o),
    .wb_dat_i(bus.wb_dat_i),
    .wb_ack_i(bus.wb_ack),
    .wb_err_i(bus.wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge with the bridge idle; returns at the negedge of the
  // response cycle so the next request can be offered in that same cycle.
  task automatic run_txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rd_dat,
                         input int waits, input int kind);
    bit          respond;
    int          exp_stb;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          stb_cycles;
    bit          done;

    respond   = (kind != K_NONE) && (waits < T);
    exp_stb   = respond ? waits + 1 : T;
    exp_err   = !respond || (kind != K_ACK);
    exp_rdata = (exp_err || we) ? 32'h0 : rd_dat;

    bus.req   = 1'b1;
    bus.we    = we;
    bus.be    = be;
    bus.addr  = addr;
    bus.wdata = wdata;
    #1;
    check("gnt_idle", {31'b0, bus.gnt}, 32'h1);
    @(posedge clk);
    #1;
    // Requests while busy must be ignored, so keep the request lines noisy.
    bus.req   = 1'($urandom);
    bus.we    = 1'($urandom);
    bus.be    = 4'($urandom);
    bus.addr  = $urandom;
    bus.wdata = $urandom;

    stb_cycles = 0;
    done       = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (bus.wb_stb) begin
        stb_cycles++;
        check("bus_cyc",    {31'b0, bus.wb_cyc}, 32'h1);
        check("bus_we",     {31'b0, bus.wb_we},  {31'b0, we});
        check("bus_sel",    {28'b0, bus.wb_sel}, {28'b0, be});
        check("bus_adr",    bus.wb_adr,          addr);
        check("bus_dat",    bus.wb_dat_o,        wdata);
        check("bus_gnt",    {31'b0, bus.gnt},    32'h0);
        check("bus_rvalid", {31'b0, bus.rvalid}, 32'h0);
        if (respond && c == waits) begin
          bus.wb_ack   = (kind == K_ACK) || (kind == K_BOTH);
          bus.wb_err   = (kind == K_ERR) || (kind == K_BOTH);
          bus.wb_dat_i = rd_dat;
        end
        @(posedge clk);
        #1;
        bus.wb_ack   = 1'b0;
        bus.wb_err   = 1'b0;
        bus.wb_dat_i = $urandom;
      end else begin
        done = 1'b1;
      end
    end
    bus.req = 1'b0;
    if (!done) check("bus_end_bound", 32'h0, 32'h1);
    check("stb_cycles", stb_cycles,           exp_stb);
    check("rsp_cyc",    {31'b0, bus.wb_cyc},  32'h0);
    check("rsp_rvalid", {31'b0, bus.rvalid},  32'h1);
    check("rsp_err",    {31'b0, bus.err},     {31'b0, exp_err});
    check("rsp_rdata",  bus.rdata,            exp_rdata);
  endtask

  // Idle cycles with stray Wishbone responses that must never produce rvalid.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bus.req      = 1'b0;
      bus.wb_ack   = 1'($urandom);
      bus.wb_err   = 1'($urandom);
      bus.wb_dat_i = $urandom;
      @(posedge clk);
      #1;
      bus.wb_ack = 1'b0;
      bus.wb_err = 1'b0;
      @(negedge clk);
      check("idle_rvalid", {31'b0, bus.rvalid}, 32'h0);
      check("idle_stb",    {31'b0, bus.wb_stb}, 32'h0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cyc"},    {31'b0, bus.wb_cyc},  32'h0);
    check({tag, "_stb"},    {31'b0, bus.wb_stb},  32'h0);
    check({tag, "_we"},     {31'b0, bus.wb_we},   32'h0);
    check({tag, "_sel"},    {28'b0, bus.wb_sel},  32'h0);
    check({tag, "_adr"},    bus.wb_adr,           32'h0);
    check({tag, "_dat"},    bus.wb_dat_o,         32'h0);
    check({tag, "_rvalid"}, {31'b0, bus.rvalid},  32'h0);
    check({tag, "_rdata"},  bus.rdata,            32'h0);
    check({tag, "_err"},    {31'b0, bus.err},     32'h0);
  endtask

  task automatic reset_mid_bus();
    bus.req   = 1'b1;
    bus.we    = 1'b1;
    bus.be    = 4'hF;
    bus.addr  = 32'h0000_0400;
    bus.wdata = 32'hA5A5_5A5A;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    @(negedge clk);
    check("rst_pre_stb", {31'b0, bus.wb_stb}, 32'h1);
    bus.wb_ack   = 1'b1;
    bus.wb_dat_i = 32'h1111_2222;
    rst_n        = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_hold_rvalid", {31'b0, bus.rvalid}, 32'h0);
    end
    bus.wb_ack = 1'b0;
    rst_n      = 1'b1;
  endtask

  initial begin
    logic        we;
    logic [31:0] wdata;
    int          kind_sel;
    int          kind;

    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    bus.req      = 1'b0;
    bus.we       = 1'b0;
    bus.be       = 4'h0;
    bus.addr     = 32'h0;
    bus.wdata    = 32'h0;
    bus.wb_dat_i = 32'h0;
    bus.wb_ack   = 1'b0;
    bus.wb_err   = 1'b0;
    #3;
    check_reset_outputs("reset");

    @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait read, then a 3-wait-state halfword write.
    run_txn(1'b0, 4'hF, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, K_ACK);
    run_txn(1'b1, 4'h3, 32'h0000_0204, 32'h1234_5678, 32'hCAFE_F00D, 3, K_ACK);
    // Timeout, with the next request offered in the error-response cycle.
    run_txn(1'b0, 4'hF, 32'h0000_0300, 32'h0, 32'h5555_AAAA, 0, K_NONE);
    run_txn(1'b0, 4'hF, 32'h0000_0304, 32'h0, 32'hFFFF_FFFF, 1, K_BOTH);
    idle_cycles(3);
    // Three back-to-back zero-wait reads.
    run_txn(1'b0, 4'hF, 32'h0000_1000, 32'h0, 32'h0000_0001, 0, K_ACK);
    run_txn(1'b0, 4'hF, 32'h0000_1004, 32'h0, 32'h0000_0002, 0, K_ACK);
    run_txn(1'b0, 4'hF, 32'h0000_1008, 32'h0, 32'h0000_0003, 0, K_ACK);
    idle_cycles(1);

    reset_mid_bus();
    run_txn(1'b0, 4'hF, 32'h0000_0500, 32'h0, 32'h7777_8888, 0, K_ACK);

    for (int n = 0; n < 60; n++) begin
      we       = 1'($urandom);
      wdata    = $urandom;
      kind_sel = int'($urandom_range(0, 9));
      kind     = (kind_sel < 6) ? K_ACK : (kind_sel < 8) ? K_ERR : (kind_sel < 9) ? K_BOTH : K_NONE;
      run_txn(we, 4'($urandom), $urandom, wdata, $urandom, int'($urandom_range(0, 5)), kind);
      if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 3)));
    end
    idle_cycles(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
